lhn_seq_divider: RTL and testbench



---
 rtl/lhn_seq_divider_pkg.sv | 11 +
 rtl/lhn_div_step.sv | 17 +
 rtl/lhn_seq_divider.sv | 109 ++++++++++
 tb/tb_lhn_seq_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lhn_seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package lhn_seq_divider_pkg;
  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/lhn_div_step.sv
// One restoring shift-and-subtract step: produces one quotient bit and the next partial remainder.
module lhn_div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   i_r,
  input  logic          i_q_msb,
  input  logic [VW-1:0] i_d,
  output logic [VW:0]   o_r,
  output logic          o_qbit
);
  logic [VW+1:0] w_t;

  // R stays below D, so the top bit of T is zero and the subtraction fits VW+1 bits
  assign w_t    = {i_r, i_q_msb};
  assign o_qbit = (w_t >= (VW+2)'(i_d));
  assign o_r    = o_qbit ? (VW+1)'(w_t - (VW+2)'(i_d)) : w_t[VW:0];
endmodule

// File: rtl/lhn_seq_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
module lhn_seq_divider
  import lhn_seq_divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_dz,
  output logic [DW-1:0] o_quotient,
  output logic [VW-1:0] o_remainder
);
  localparam int CW = $clog2(DW + 1);

  div_state_e    r_state;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_d;
  logic [VW:0]   r_r;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_dz;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_rem;

  logic [VW:0]   w_r_nxt;
  logic          w_qbit;
  logic [DW-1:0] w_q_nxt;

  lhn_div_step #(.VW(VW)) u_step (
    .i_r     (r_r),
    .i_q_msb (r_q[DW-1]),
    .i_d     (r_d),
    .o_r     (w_r_nxt),
    .o_qbit  (w_qbit)
  );

  assign w_q_nxt = DW'({r_q, w_qbit});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_q    <= i_dividend;
            r_d    <= i_divisor;
            r_r    <= '0;
            r_cnt  <= CW'(DW);
            r_busy <= 1'b1;
            r_dz   <= 1'b0;
            // Zero divisor skips the iteration and reports saturated quotient
            if (i_divisor == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_dz    <= 1'b1;
              r_quot  <= '1;
              r_rem   <= '0;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_quot  <= w_q_nxt;
            r_rem   <= w_r_nxt[VW-1:0];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_dz        = r_dz;
  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;
endmodule

// File: tb/tb_lhn_seq_divider.sv
// Scoreboard bench for lhn_seq_divider: driver pushes expected results, monitor checks on done.
module tb_lhn_seq_divider;
  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, dz;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned dz;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;

  lhn_seq_divider #(.DW(DW), .VW(VW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_busy      (busy),
    .o_done      (done),
    .o_dz        (dz),
    .o_quotient  (quotient),
    .o_remainder (remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, with the zero-divisor convention
  function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned k);
    exp_t e;
    if (b == 0) begin
      e.q = (1 << DW) - 1; e.r = 0; e.dz = 1; e.due = k;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 0; e.due = k + DW;
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("dz", dz, e.dz);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic launch(input int unsigned a, input int unsigned b, output int unsigned k);
    @(negedge clk);
    start = 1'b1; dividend = DW'(a); divisor = VW'(b);
    k = cyc + 1;
    sb.push_back(model(a, b, k));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4 * DW) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", 1, 0);
  endtask

  task automatic do_div(input int unsigned a, input int unsigned b);
    int unsigned k;
    launch(a, b, k);
    wait_idle();
  endtask

  initial begin
    int unsigned k;
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_div(200, 7);
    do_div(255, 15);
    do_div(5, 9);
    do_div(255, 1);
    do_div(0, 3);
    do_div(15, 15);

    // Divide by zero, held result, then cleared by the next start
    do_div(100, 0);
    @(negedge clk);
    chk("dz_held", dz, 1);
    chk("quot_held", quotient, 255);
    launch(200, 7, k);
    chk("dz_cleared_on_start", dz, 0);
    wait_idle();

    // Starts during RUN and in the done cycle must be ignored
    launch(200, 7, k);
    while (cyc != k + 2) @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    while (cyc != k + DW && cyc < k + 4 * DW) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_drops", busy, 0);
    repeat (DW + 2) @(negedge clk);
    chk("no_queued_start", busy, 0);

    // Reset mid-operation aborts with no done
    launch(200, 7, k);
    while (cyc != k + 3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dz", dz, 0);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (DW + 3) @(negedge clk);
    chk("abort_idle", busy, 0);
    do_div(100, 3);

    for (int i = 0; i < 150; i++)
      do_div($urandom_range(255, 0), $urandom_range(15, 0));

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
